freq_gate_ctrl: RTL and testbench

Measurement sequencer for the digital frequency meter's cascaded decade-counter chain. It runs the clear → gate → settle → latch cycle that drives the chain's enable and clear inputs and the display latch. It also auto-ranges the gate time between 1 s, 100 ms and 10 ms using chain overflow and most-significant-digit-zero feedback. It runs on the system clock; the counter chain itself is clocked by fin.

---
 rtl/freq_gate_ctrl.sv | 143 ++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the decade-counter frequency meter: clear, gate, settle, latch,
// with gate-time auto-ranging driven by chain overflow and top-digit-zero feedback.
module freq_gate_ctrl #(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned CLR_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_RERANGE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       auto_range,
  input  logic [1:0] range_init,
  input  logic       abort,
  input  logic       cnt_ovf,
  input  logic       msd_zero,
  output logic       cnt_en,
  output logic       cnt_clear,
  output logic       latch_en,
  output logic [1:0] range,
  output logic       busy,
  output logic       done,
  output logic       over_range
);

  localparam int unsigned MAX_A = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C = (CLK_FREQ > MAX_A) ? CLK_FREQ : MAX_A;
  localparam int unsigned CW    = $clog2(MAX_C + 1);
  localparam int unsigned RW    = (MAX_RERANGE < 1) ? 1 : $clog2(MAX_RERANGE + 1);

  localparam logic [CW-1:0] G0_END     = CW'(CLK_FREQ - 1);
  localparam logic [CW-1:0] G1_END     = CW'(CLK_FREQ / 10 - 1);
  localparam logic [CW-1:0] G2_END     = CW'(CLK_FREQ / 100 - 1);
  localparam logic [CW-1:0] CLR_END    = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RERANGE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;

  logic [2:0]    state, next_state;
  logic [CW-1:0] cnt, gate_end;
  logic [RW-1:0] retries;
  logic          ovf_s1, ovf_s2, ovf_flag, ovf_eff;
  logic          dec_up, dec_down;
  logic          up_c, down_c, accept_now;
  logic [1:0]    range_load;

  always_comb begin
    case (range)
      2'd0:    gate_end = G0_END;
      2'd1:    gate_end = G1_END;
      default: gate_end = G2_END;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR:  if (cnt == CLR_END) next_state = S_GATE;
      S_GATE:   if (cnt == gate_end) next_state = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_END) next_state = S_LATCH;
      S_LATCH:  next_state = (dec_up || dec_down || continuous) ? S_CLEAR : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // The range decision is resolved on the edge entering LATCH so that latch_en/done,
  // being registered, are high during the LATCH cycle itself.
  always_comb begin
    ovf_eff    = ovf_flag | ovf_s2;
    up_c       = auto_range && ovf_eff && (range < 2'd2) && (retries < RETRY_MAX);
    down_c     = auto_range && !ovf_eff && msd_zero && (range != 2'd0) && (retries < RETRY_MAX);
    accept_now = (state == S_SETTLE) && (next_state == S_LATCH) && !up_c && !down_c;
    range_load = (range_init == 2'd3) ? 2'd2 : range_init;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      retries    <= '0;
      ovf_s1     <= 1'b0;
      ovf_s2     <= 1'b0;
      ovf_flag   <= 1'b0;
      dec_up     <= 1'b0;
      dec_down   <= 1'b0;
      range      <= '0;
      cnt_en     <= 1'b0;
      cnt_clear  <= 1'b0;
      latch_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      over_range <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= (next_state != state) ? '0 : cnt + CW'(1);
      ovf_s1 <= cnt_ovf;
      ovf_s2 <= ovf_s1;

      if (next_state == S_CLEAR && state != S_CLEAR)
        ovf_flag <= 1'b0;
      else if ((state == S_GATE || state == S_SETTLE) && ovf_s2)
        ovf_flag <= 1'b1;

      if (state == S_IDLE && start && !abort) begin
        range   <= range_load;
        retries <= '0;
      end

      if (state == S_SETTLE && next_state == S_LATCH) begin
        dec_up   <= up_c;
        dec_down <= down_c;
      end

      if (state == S_LATCH && !abort) begin
        if (dec_up) begin
          range   <= range + 2'd1;
          retries <= retries + RW'(1);
        end else if (dec_down) begin
          range   <= range - 2'd1;
          retries <= retries + RW'(1);
        end else begin
          retries <= '0;
        end
      end

      cnt_clear <= (next_state == S_CLEAR);
      cnt_en    <= (next_state == S_GATE);
      busy      <= (next_state != S_IDLE);
      latch_en  <= accept_now;
      done      <= accept_now;
      if (accept_now) over_range <= ovf_eff && (range == 2'd2);
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: table of single-measurement vectors plus hand sequences
// for continuous mode, abort, reset, ignored start and the retry limit.
module tb_freq_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, continuous, auto_range, abort, cnt_ovf, msd_zero;
  logic [1:0] range_init;
  logic       cnt_en, cnt_clear, latch_en, busy, done, over_range;
  logic [1:0] range;

  int unsigned tests = 0;
  int unsigned fails = 0;

  freq_gate_ctrl #(
    .CLK_FREQ     (1000),
    .CLR_CYCLES   (4),
    .SETTLE_CYCLES(3),
    .MAX_RERANGE  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .continuous(continuous),
    .auto_range(auto_range),
    .range_init(range_init),
    .abort     (abort),
    .cnt_ovf   (cnt_ovf),
    .msd_zero  (msd_zero),
    .cnt_en    (cnt_en),
    .cnt_clear (cnt_clear),
    .latch_en  (latch_en),
    .range     (range),
    .busy      (busy),
    .done      (done),
    .over_range(over_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ri;
    bit         aut;
    bit         ovf;
    bit         msd;
    int         n_clear;
    int         n_en;
    int         t_done;
    int         rng;
    int         over;
    int         changes;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_done(input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) nd++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, nc, ne, nl, nd, coll, mism, t_done, over_at, rng_at, chg;
    logic [1:0] prev;
    bit fin;
    range_init = v.ri; auto_range = v.aut; cnt_ovf = v.ovf; msd_zero = v.msd; continuous = 0;
    repeat (3) step();
    start = 1; step(); start = 0;
    cyc = 1; nc = 0; ne = 0; nl = 0; nd = 0; coll = 0; mism = 0;
    t_done = -1; over_at = -1; rng_at = -1; chg = 0; fin = 0; prev = range;
    while (!fin && cyc < 3000) begin
      if (cnt_clear) nc++;
      if (cnt_en) ne++;
      if (cnt_en && cnt_clear) coll++;
      if (latch_en) nl++;
      if (latch_en != done) mism++;
      if (done) begin nd++; t_done = cyc; over_at = int'(over_range); rng_at = int'(range); end
      if (range != prev) chg++;
      prev = range;
      if (!busy) fin = 1;
      else begin step(); cyc++; end
    end
    check($sformatf("v%0d finished", idx), int'(fin), 1);
    check($sformatf("v%0d clear_cycles", idx), nc, v.n_clear);
    check($sformatf("v%0d gate_cycles", idx), ne, v.n_en);
    check($sformatf("v%0d done_count", idx), nd, 1);
    check($sformatf("v%0d latch_count", idx), nl, 1);
    check($sformatf("v%0d latch_done_coincide", idx), mism, 0);
    check($sformatf("v%0d en_clear_overlap", idx), coll, 0);
    check($sformatf("v%0d done_cycle", idx), t_done, v.t_done);
    check($sformatf("v%0d busy_fall", idx), cyc, v.t_done + 1);
    check($sformatf("v%0d range_at_done", idx), rng_at, v.rng);
    check($sformatf("v%0d over_at_done", idx), over_at, v.over);
    check($sformatf("v%0d range_changes", idx), chg, v.changes);
    step();
    check($sformatf("v%0d over_held", idx), int'(over_range), v.over);
    cnt_ovf = 0; msd_zero = 0;
  endtask

  initial begin
    int nd, t1, t2, t3, cyc, guard;

    //            ri    aut ovf msd clr  en    done  rng over chg
    vecs[0] = '{2'd0, 0, 0, 0, 4,  1000, 1008, 0, 0, 0};
    vecs[1] = '{2'd2, 0, 0, 0, 4,  10,   18,   2, 0, 0};
    vecs[2] = '{2'd3, 0, 0, 0, 4,  10,   18,   2, 0, 0};
    vecs[3] = '{2'd0, 1, 1, 0, 12, 1110, 1134, 2, 1, 2};
    vecs[4] = '{2'd2, 1, 0, 1, 12, 1110, 1134, 0, 0, 2};
    vecs[5] = '{2'd1, 0, 1, 0, 4,  100,  108,  1, 0, 0};
    vecs[6] = '{2'd2, 0, 1, 1, 4,  10,   18,   2, 1, 0};
    vecs[7] = '{2'd1, 1, 0, 1, 8,  1100, 1116, 0, 0, 1};

    rst = 1; start = 0; continuous = 0; auto_range = 0; range_init = 0;
    abort = 0; cnt_ovf = 0; msd_zero = 0;
    step(); step();
    check("reset cnt_en", int'(cnt_en), 0);
    check("reset cnt_clear", int'(cnt_clear), 0);
    check("reset latch_en", int'(latch_en), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    check("reset over_range", int'(over_range), 0);
    check("reset range", int'(range), 0);
    rst = 0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Continuous mode: period 4+10+3+1 = 18; continuous dropped mid third cycle.
    range_init = 2; auto_range = 0; continuous = 1;
    step(); start = 1; step(); start = 0;
    cyc = 1; nd = 0; t1 = -1; t2 = -1; t3 = -1;
    while (cyc < 200 && (busy || cyc < 2)) begin
      if (done) begin
        nd++;
        if (nd == 1) t1 = cyc; else if (nd == 2) t2 = cyc; else if (nd == 3) t3 = cyc;
      end
      if (cyc == 40) continuous = 0;
      step(); cyc++;
    end
    check("cont done_count", nd, 3);
    check("cont done1", t1, 18);
    check("cont done2", t2, 36);
    check("cont done3", t3, 54);
    check("cont busy_fall", cyc, 55);

    // Abort during GATE at range 1.
    range_init = 1; step(); start = 1; step(); start = 0;
    repeat (9) step();
    check("abort pre gate", int'(cnt_en), 1);
    abort = 1; step(); abort = 0;
    check("abort cnt_en", int'(cnt_en), 0);
    check("abort cnt_clear", int'(cnt_clear), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort range held", int'(range), 1);
    count_done(200, nd);
    check("abort no done", nd, 0);

    // start pulsed during GATE is ignored.
    range_init = 2; step(); start = 1; step(); start = 0;
    cyc = 1; t1 = -1;
    for (int i = 0; i < 40; i++) begin
      if (cyc == 8) start = 1; else start = 0;
      if (done && t1 < 0) t1 = cyc;
      step(); cyc++;
    end
    check("restart ignored done", t1, 18);
    check("restart ignored idle", int'(busy), 0);

    // Reset mid-GATE.
    range_init = 1; step(); start = 1; step(); start = 0;
    repeat (10) step();
    rst = 1; step();
    check("rst cnt_en", int'(cnt_en), 0);
    check("rst busy", int'(busy), 0);
    check("rst range", int'(range), 0);
    check("rst over_range", int'(over_range), 0);
    rst = 0;
    count_done(150, nd);
    check("rst no done", nd, 0);

    // Retry limit: up 0->1, down 1->0, then overflow at range 0 must be accepted.
    range_init = 0; auto_range = 1; cnt_ovf = 1; msd_zero = 0;
    step(); start = 1; step(); start = 0;
    cyc = 1; nd = 0; t1 = -1; guard = 0;
    while (busy && cyc < 3000) begin
      if (range == 2'd1 && guard == 0) begin cnt_ovf = 0; msd_zero = 1; guard = 1; end
      if (range == 2'd0 && guard == 1) begin cnt_ovf = 1; msd_zero = 0; guard = 2; end
      if (done) begin nd++; t1 = cyc; t2 = int'(range); t3 = int'(over_range); end
      step(); cyc++;
    end
    check("retry done_count", nd, 1);
    check("retry done_cycle", t1, 2124);
    check("retry range", t2, 0);
    check("retry over", t3, 0);
    cnt_ovf = 0; auto_range = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
